// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared types and address widths for the BNN layer scheduler and core controller
package bnn_pkg;

    localparam int WADDR_W = 9;
    localparam int ALPHA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        KICK,
        WAIT_BUSY,
        WAIT_IDLE,
        NEXT,
        DONE
    } sched_state_t;

    typedef struct packed {
        logic [WADDR_W-1:0] wbase;
        logic [ALPHA_W-1:0] abase;
    } layer_desc_t;

endpackage

// File: rtl/bnn_desc_table.sv
// rtl/bnn_desc_table.sv - per-layer descriptor storage, one write port and one asynchronous read port
module bnn_desc_table
    import bnn_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        we_i,
    input  logic [AW-1:0] waddr_i,
    input  layer_desc_t wdata_i,
    input  logic [AW-1:0] raddr_i,
    output layer_desc_t rdata_o
);

    // Contents are intentionally not reset; the host reloads the table before use.
    layer_desc_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bnn_layer_sched.sv
// rtl/bnn_layer_sched.sv - multi-layer run scheduler driving the BNN core controller
// Optional watchdog: define BNN_SCHED_WDOG_EN to bound the core wait states.
module bnn_layer_sched
    import bnn_pkg::*;
#(
    parameter int MAX_LAYERS = 8,
    parameter int WADDR_W    = bnn_pkg::WADDR_W,
    parameter int ALPHA_W    = bnn_pkg::ALPHA_W,
    parameter int WDOG_W     = 16,
    localparam int IDX_W     = $clog2(MAX_LAYERS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_addr,
    input  logic [WADDR_W-1:0] cfg_wbase,
    input  logic [ALPHA_W-1:0] cfg_abase,
    input  logic [IDX_W:0]     num_layers,
    input  logic               run_start,
    output logic               run_busy,
    output logic               run_done,
    output logic               run_err,
    output logic [IDX_W-1:0]   layer_idx,
    output logic [WADDR_W-1:0] weight_base,
    output logic [ALPHA_W-1:0] alpha_base,
    output logic               act_bank,
    output logic               core_start,
    input  logic               core_idle
);

    localparam logic [IDX_W:0]   MAX_N   = (IDX_W+1)'(MAX_LAYERS);
    localparam logic [IDX_W:0]   N_ONE   = {{IDX_W{1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    if ((MAX_LAYERS & (MAX_LAYERS - 1)) != 0 || MAX_LAYERS < 2 || WDOG_W < 2) begin : g_bad_cfg
        $error("bnn_layer_sched: MAX_LAYERS must be a power of 2 >= 2 and WDOG_W >= 2");
    end

    sched_state_t       state_q, state_d;
    logic [IDX_W:0]     num_q, num_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WADDR_W-1:0] wbase_q, wbase_d;
    logic [ALPHA_W-1:0] abase_q, abase_d;
    logic               bank_q, bank_d;
    logic               err_q, err_d;
    layer_desc_t        wr_desc, rd_desc;

`ifdef BNN_SCHED_WDOG_EN
    localparam logic [WDOG_W-1:0] WDOG_ONE = {{(WDOG_W-1){1'b0}}, 1'b1};
    logic [WDOG_W-1:0] wdog_q, wdog_d;
`endif

    assign wr_desc.wbase = cfg_wbase;
    assign wr_desc.abase = cfg_abase;

    // The table is frozen for the whole run so LOAD never races a host write.
    bnn_desc_table #(.DEPTH(MAX_LAYERS), .AW(IDX_W)) u_table (
        .clk     (clk),
        .we_i    (cfg_we && (state_q == IDLE)),
        .waddr_i (cfg_addr),
        .wdata_i (wr_desc),
        .raddr_i (idx_q),
        .rdata_o (rd_desc)
    );

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        idx_d   = idx_q;
        wbase_d = wbase_q;
        abase_d = abase_q;
        bank_d  = bank_q;
        err_d   = err_q;
`ifdef BNN_SCHED_WDOG_EN
        wdog_d  = wdog_q;
`endif
        case (state_q)
            IDLE: begin
                if (run_start) begin
                    num_d   = (num_layers > MAX_N) ? MAX_N : num_layers;
                    idx_d   = '0;
                    bank_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = (num_layers == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                wbase_d = rd_desc.wbase;
                abase_d = rd_desc.abase;
                state_d = KICK;
            end
            KICK: begin
`ifdef BNN_SCHED_WDOG_EN
                wdog_d  = '0;
`endif
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: if (!core_idle) state_d = WAIT_IDLE;
            WAIT_IDLE: if (core_idle) state_d = NEXT;
            NEXT: begin
                bank_d = ~bank_q;
                if ({1'b0, idx_q} == num_q - N_ONE) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = LOAD;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef BNN_SCHED_WDOG_EN
        if (state_q == WAIT_BUSY || state_q == WAIT_IDLE) begin
            if (&wdog_q) begin
                err_d   = 1'b1;
                state_d = DONE;
            end else begin
                wdog_d  = wdog_q + WDOG_ONE;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            num_q   <= '0;
            idx_q   <= '0;
            wbase_q <= '0;
            abase_q <= '0;
            bank_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef BNN_SCHED_WDOG_EN
            wdog_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            wbase_q <= wbase_d;
            abase_q <= abase_d;
            bank_q  <= bank_d;
            err_q   <= err_d;
`ifdef BNN_SCHED_WDOG_EN
            wdog_q  <= wdog_d;
`endif
        end
    end

    assign run_busy    = (state_q != IDLE);
    assign run_done    = (state_q == DONE);
    assign core_start  = (state_q == KICK);
    assign run_err     = err_q;
    assign layer_idx   = idx_q;
    assign weight_base = wbase_q;
    assign alpha_base  = abase_q;
    assign act_bank    = bank_q;

endmodule

// File: tb/tb_bnn_layer_sched.sv
// tb/tb_bnn_layer_sched.sv - randomized self-checking bench for bnn_layer_sched
module tb_bnn_layer_sched;

    localparam int ML = 8;
    localparam int IW = 3;
    localparam int WW = 9;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_addr = '0;
    logic [WW-1:0] cfg_wbase = '0;
    logic [AW-1:0] cfg_abase = '0;
    logic [IW:0]   num_layers = '0;
    logic          run_start = 1'b0;
    logic          run_busy, run_done, run_err, act_bank, core_start, core_idle;
    logic [IW-1:0] layer_idx;
    logic [WW-1:0] weight_base;
    logic [AW-1:0] alpha_base;

    int total = 0;
    int bad = 0;
    int core_cnt = 0;
    bit stuck = 1'b0;
    int busy_q[$];
    logic [WW-1:0] tw [ML];
    logic [AW-1:0] ta [ML];

    bnn_layer_sched #(.MAX_LAYERS(ML), .WADDR_W(WW), .ALPHA_W(AW), .WDOG_W(4)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wbase(cfg_wbase), .cfg_abase(cfg_abase), .num_layers(num_layers),
        .run_start(run_start), .run_busy(run_busy), .run_done(run_done),
        .run_err(run_err), .layer_idx(layer_idx), .weight_base(weight_base),
        .alpha_base(alpha_base), .act_bank(act_bank), .core_start(core_start),
        .core_idle(core_idle)
    );

    always #5 clk = ~clk;

    // Core stand-in: goes busy the cycle after a start pulse for a random 1..12 cycles.
    always @(posedge clk) begin
        if (core_start) begin
            int b;
            b = $urandom_range(1, 12);
            core_cnt <= b;
            busy_q.push_back(b);
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
        end
    end
    assign core_idle = (core_cnt == 0) && !stuck;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_desc(input int i, input logic [WW-1:0] w, input logic [AW-1:0] a);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = i[IW-1:0]; cfg_wbase = w; cfg_abase = a;
        tw[i] = w; ta[i] = a;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic run(input int n, input bit hold, input bit poke);
        int eff, kicks, cycles, sum;
        bit seen;
        eff = (n > ML) ? ML : n;
        busy_q.delete();
        @(negedge clk);
        num_layers = n[IW:0]; run_start = 1'b1;
        cycles = 1; kicks = 0; seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            cycles++;
            if (!hold) run_start = 1'b0;
            if (poke && c == 0) begin
                cfg_we = 1'b1; cfg_addr = 3'd1; cfg_wbase = 9'h1FF; cfg_abase = 8'hAA;
            end else begin
                cfg_we = 1'b0;
            end
            if (core_start) begin
                if (kicks < eff) begin
                    check("kick_wbase", weight_base, tw[kicks]);
                    check("kick_abase", alpha_base, ta[kicks]);
                    check("kick_idx", layer_idx, kicks);
                    check("kick_bank", act_bank, kicks % 2);
                end
                kicks++;
            end
            if (run_done) seen = 1'b1;
        end
        check("done_seen", seen, 1);
        check("kicks", kicks, eff);
        sum = 0;
        foreach (busy_q[i]) sum += 3 + busy_q[i] + 1;
        check("latency", cycles, 1 + sum + 1);
        check("bank_end", act_bank, eff % 2);
        check("err_end", run_err, 0);
        if (!hold) begin
            @(negedge clk);
            check("busy_after", run_busy, 0);
            check("done_width", run_done, 0);
        end
    endtask

    initial begin
        int kicks;
        int cycles;
        bit seen;
        repeat (3) @(negedge clk);
        check("rst_busy", run_busy, 0);
        check("rst_done", run_done, 0);
        check("rst_err", run_err, 0);
        check("rst_idx", layer_idx, 0);
        check("rst_wbase", weight_base, 0);
        check("rst_abase", alpha_base, 0);
        check("rst_bank", act_bank, 0);
        check("rst_kick", core_start, 0);
        rst = 1'b1;

        write_desc(0, 9'h000, 8'h00);
        write_desc(1, 9'h040, 8'h20);
        write_desc(2, 9'h080, 8'h40);
        for (int i = 3; i < ML; i++) write_desc(i, $urandom_range(0, 511), $urandom_range(0, 255));

        run(3, 1'b0, 1'b0);
        run(0, 1'b0, 1'b0);
        run(3, 1'b0, 1'b1);
        run(2, 1'b0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < ML; i++) write_desc(i, $urandom_range(0, 511), $urandom_range(0, 255));
            run($urandom_range(1, ML), 1'b0, 1'b0);
        end
        run(12, 1'b0, 1'b0);

        // run_start held: one run completes, next accepted on the cycle after DONE
        run(2, 1'b1, 1'b0);
        @(negedge clk);
        check("hold_idle_gap", run_busy, 0);
        @(negedge clk);
        check("hold_reaccept", run_busy, 1);
        check("hold_idx", layer_idx, 0);
        run_start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            if (run_done) seen = 1'b1;
        end
        check("hold_drain", seen, 1);

        // Reset asserted while waiting on the core during layer 2
        @(negedge clk);
        num_layers = 4'd3; run_start = 1'b1;
        kicks = 0;
        for (int c = 0; c < 2000 && kicks < 3; c++) begin
            @(negedge clk);
            run_start = 1'b0;
            if (core_start) kicks++;
        end
        check("rst_mid_kicks", kicks, 3);
        repeat (2) @(negedge clk);
        check("rst_mid_idx_before", layer_idx, 2);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", run_busy, 0);
        check("rst_mid_kick", core_start, 0);
        check("rst_mid_idx", layer_idx, 0);
        check("rst_mid_bank", act_bank, 0);
        check("rst_mid_wbase", weight_base, 0);
        check("rst_mid_done", run_done, 0);
        rst = 1'b1;
        for (int c = 0; c < 100 && !core_idle; c++) @(negedge clk);
        for (int i = 0; i < ML; i++) write_desc(i, $urandom_range(0, 511), $urandom_range(0, 255));
        run(2, 1'b0, 1'b0);

`ifdef BNN_SCHED_WDOG_EN
        // Watchdog: LOAD, KICK, then 16 wait cycles before the forced DONE
        stuck = 1'b1;
        @(negedge clk);
        num_layers = 4'd1; run_start = 1'b1;
        cycles = 1; seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            run_start = 1'b0;
            cycles++;
            if (run_done) seen = 1'b1;
        end
        check("wdog_done", seen, 1);
        check("wdog_latency", cycles, 20);
        check("wdog_err", run_err, 1);
        @(negedge clk);
        check("wdog_err_hold", run_err, 1);
        check("wdog_busy", run_busy, 0);
        stuck = 1'b0;
        for (int c = 0; c < 100 && !core_idle; c++) @(negedge clk);
        run(1, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
